// File: rtl/sha256_pkg.sv
// Shared widths and types for the SHA-256 datapath front end.
package sha256_pkg;

    localparam int BLOCK_W         = 512;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

endpackage

// File: rtl/sha256_block_fifo2.sv
// Two-entry register FIFO with valid/ready handshakes; the head register drives data_o
// directly and keeps the last popped entry once the FIFO drains.
module sha256_block_fifo2 #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push_ok = push_i && (count_q != 2'd2);
        pop_ok  = pop_i && (count_q != 2'd0);
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) head_d = data_i;
                else                 tail_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // With one entry left the head is kept so block_out holds the last popped block.
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry: the new block replaces the retiring head.
                head_d = data_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sha256_input_stage.sv
// Host-facing input stage: buffers up to two message blocks ahead of the compression core.
// Optional build macro SHA256_INPUT_STAGE_CNT_EN adds accepted-block and overflow monitors.
module sha256_input_stage #(
    parameter int BLOCK_W = 512,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] block_in,
    output logic               ready,
    output logic               input_valid,
    output logic [BLOCK_W-1:0] block_out,
`ifdef SHA256_INPUT_STAGE_CNT_EN
    output logic [31:0]        blocks_accepted,
    output logic               overflow_seen,
`endif
    input  logic               next_stage_ready
);

    import sha256_pkg::*;

    if (DEPTH != 2 || (BLOCK_W % WORD_W) != 0) begin : g_bad_cfg
        $error("sha256_input_stage: DEPTH must be 2 and BLOCK_W a multiple of 32");
    end

    logic full;

    sha256_block_fifo2 #(
        .W (BLOCK_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (start),
        .data_i  (block_in),
        .full_o  (full),
        .pop_i   (next_stage_ready),
        .valid_o (input_valid),
        .data_o  (block_out)
    );

    // ready comes only from the registered count, never from next_stage_ready.
    assign ready = !full;

`ifdef SHA256_INPUT_STAGE_CNT_EN
    logic [31:0] accepted_q, accepted_d;
    logic        overflow_q, overflow_d;

    always_comb begin
        accepted_d = accepted_q;
        overflow_d = overflow_q;
        if (start && ready)  accepted_d = accepted_q + 32'd1;
        if (start && !ready) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            accepted_q <= accepted_d;
            overflow_q <= overflow_d;
        end
    end

    assign blocks_accepted = accepted_q;
    assign overflow_seen   = overflow_q;
`endif

endmodule

// File: tb/tb_sha256_input_stage.sv
// Self-checking bench for sha256_input_stage: directed scenarios then random traffic
// against a queue-based model of the two-block buffer.
module tb_sha256_input_stage;

    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] block_in;
    logic          ready;
    logic          input_valid;
    logic [BW-1:0] block_out;
    logic          next_stage_ready;
`ifdef SHA256_INPUT_STAGE_CNT_EN
    logic [31:0]   blocks_accepted;
    logic          overflow_seen;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an ordered list of queued blocks plus the last block handed out.
    logic [BW-1:0] m_q[$];
    logic [BW-1:0] m_last;
    logic [31:0]   m_acc;
    logic          m_ovf;

    sha256_input_stage #(.BLOCK_W(BW), .DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .block_in         (block_in),
        .ready            (ready),
        .input_valid      (input_valid),
        .block_out        (block_out),
`ifdef SHA256_INPUT_STAGE_CNT_EN
        .blocks_accepted  (blocks_accepted),
        .overflow_seen    (overflow_seen),
`endif
        .next_stage_ready (next_stage_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Apply one clock with the current inputs, advance the model, compare all outputs.
    task automatic step();
        bit room;
        bit have;
        room = (m_q.size() < 2);
        have = (m_q.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_last = '0;
            m_acc  = '0;
            m_ovf  = 1'b0;
        end else begin
            if (have && next_stage_ready) m_last = m_q.pop_front();
            if (start && room) begin
                m_q.push_back(block_in);
                m_acc = m_acc + 32'd1;
            end
            if (start && !room) m_ovf = 1'b1;
        end
        check("ready", BW'(ready), BW'(m_q.size() < 2));
        check("input_valid", BW'(input_valid), BW'(m_q.size() > 0));
        check("block_out", block_out, (m_q.size() > 0) ? m_q[0] : m_last);
`ifdef SHA256_INPUT_STAGE_CNT_EN
        check("blocks_accepted", BW'(blocks_accepted), BW'(m_acc));
        check("overflow_seen", BW'(overflow_seen), BW'(m_ovf));
`endif
    endtask

    task automatic cyc(input logic r, input logic s, input logic [BW-1:0] b, input logic nsr);
        rst              = r;
        start            = s;
        block_in         = b;
        next_stage_ready = nsr;
        step();
    endtask

    logic [BW-1:0] blk_abcd, blk_1234, blk_a, blk_c;

    initial begin
        m_last = '0;
        m_acc  = '0;
        m_ovf  = 1'b0;
        rst = 1'b1; start = 1'b1; block_in = '1; next_stage_ready = 1'b0;
        blk_abcd = {32'h61626364, 480'h0};
        blk_1234 = {32'h12345678, 480'h0};
        blk_a    = {16{32'hAAAAAAAA}};
        blk_c    = {16{32'h0F0F0F0F}};

        // Reset (start high during reset must be ignored).
        cyc(1, 1, blk_c, 0);
        cyc(1, 1, blk_c, 0);
        cyc(0, 0, blk_c, 0);
        check("rst_ready", BW'(ready), BW'(1'b1));
        check("rst_valid", BW'(input_valid), BW'(1'b0));
        check("rst_block_out", block_out, '0);

        // Single block, downstream always ready: valid for exactly one cycle.
        cyc(0, 1, blk_abcd, 1);
        check("first_out", block_out, blk_abcd);
        cyc(0, 0, blk_c, 1);
        check("first_drained", BW'(input_valid), BW'(1'b0));
        check("empty_retains", block_out, blk_abcd);

        // Back-pressure hold.
        cyc(0, 1, blk_1234, 0);
        cyc(0, 0, blk_c, 0);
        cyc(0, 0, blk_c, 0);
        check("hold_out", block_out, blk_1234);
        cyc(0, 0, blk_c, 1);

        // Fill to two, third push ignored, then drain A then B.
        cyc(0, 1, blk_a, 0);
        cyc(0, 1, blk_1234, 0);
        check("full_ready", BW'(ready), BW'(1'b0));
        cyc(0, 1, blk_c, 0);
        cyc(0, 1, blk_c, 1);  // pop while full: push still ignored
        check("pop_a_then_b", block_out, blk_1234);
        cyc(0, 0, blk_c, 1);
        check("drained_keeps_b", block_out, blk_1234);
`ifdef SHA256_INPUT_STAGE_CNT_EN
        check("overflow_set", BW'(overflow_seen), BW'(1'b1));
`endif

        // count=1 with simultaneous push and pop.
        cyc(0, 1, blk_a, 0);
        cyc(0, 1, blk_abcd, 1);
        check("swap_head", block_out, blk_abcd);
        check("swap_valid", BW'(input_valid), BW'(1'b1));
        cyc(0, 0, blk_c, 1);

        // Continuous start with downstream always ready.
        for (int i = 0; i < 6; i++) cyc(0, 1, rand_block(), 1);
        cyc(0, 0, blk_c, 1);

        // Reset with two queued blocks.
        cyc(0, 1, blk_a, 0);
        cyc(0, 1, blk_1234, 0);
        cyc(1, 1, blk_c, 0);
        check("midrst_valid", BW'(input_valid), BW'(1'b0));
        check("midrst_out", block_out, '0);
`ifdef SHA256_INPUT_STAGE_CNT_EN
        check("midrst_acc", BW'(blocks_accepted), '0);
`endif

        // Random traffic, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                rand_block(), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
